// File: rtl/load_unit.sv
// load_unit -- MEM-stage data-memory load unit.
//
// Accepts one load at a time and issues a word-aligned read to data memory.
// After the memory handshake it extracts the addressed byte, halfword or word
// and sign- or zero-extends it into a registered result for the writeback
// mux. Misaligned loads, illegal funct3 values and timed-out loads are
// reported on load_fault.
//
// Handshake: in REQ, mem_req is high and mem_addr is stable. A response is
// taken in the first cycle that has mem_req=1 and mem_ready=1, unless flush is
// also high; in that case the response is dropped. No ready/valid back-pressure
// is applied to the memory side.
//
// Ports:
//   clk, reset             clock; asynchronous active-high reset
//   load_en, funct3, addr  load request from the MEM stage
//   flush                  abort any load (highest priority)
//   mem_req, mem_addr      read request to data memory (word aligned)
//   mem_ready, mem_rdata   memory response
//   load_stall             hold upstream stages and the MEM/WB register
//   load_data              extended load result
//   load_valid             one-cycle pulse: load_data is new
//   load_fault             one-cycle pulse: misaligned/illegal/timeout
//   state_dbg              current FSM state (debug)

module load_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_en,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        load_stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        load_fault,
    output logic [1:0]  state_dbg
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] F_LB  = 3'b000;
    localparam logic [2:0] F_LH  = 3'b001;
    localparam logic [2:0] F_LW  = 3'b010;
    localparam logic [2:0] F_LBU = 3'b100;
    localparam logic [2:0] F_LHU = 3'b101;

    // The last REQ cycle that may still accept mem_ready.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state_q,  state_d;
    logic [31:0] addr_q,   addr_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [7:0]  cnt_q,    cnt_d;
    logic [31:0] data_q,   data_d;
    logic        valid_q,  valid_d;
    logic        fault_q,  fault_d;

    logic        legal;
    logic        aligned;
    logic        start_ok;
    logic        start_bad;
    logic        accepting;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] ext_data;

    // Decode of the incoming request.
    always_comb begin
        legal   = 1'b0;
        aligned = 1'b1;
        case (funct3)
            F_LB, F_LBU: legal = 1'b1;
            F_LH, F_LHU: begin
                legal   = 1'b1;
                aligned = ~addr[0];
            end
            F_LW: begin
                legal   = 1'b1;
                aligned = (addr[1:0] == 2'b00);
            end
            default: legal = 1'b0;
        endcase
    end

    assign start_ok  = load_en & legal & aligned;
    assign start_bad = load_en & ~(legal & aligned);
    assign accepting = (state_q == S_IDLE) | (state_q == S_DONE);

    // Lane selection uses the captured offset, not the live address.
    always_comb begin
        case (addr_q[1:0])
            2'd0:    rd_byte = mem_rdata[7:0];
            2'd1:    rd_byte = mem_rdata[15:8];
            2'd2:    rd_byte = mem_rdata[23:16];
            default: rd_byte = mem_rdata[31:24];
        endcase
        rd_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        case (funct3_q)
            F_LB:    ext_data = {{24{rd_byte[7]}}, rd_byte};
            F_LBU:   ext_data = {24'd0, rd_byte};
            F_LH:    ext_data = {{16{rd_half[15]}}, rd_half};
            F_LHU:   ext_data = {16'd0, rd_half};
            default: ext_data = mem_rdata;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        funct3_d = funct3_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        fault_d  = 1'b0;

        if (flush) begin
            // Abort wins over everything, including a same-cycle response.
            state_d = S_IDLE;
            cnt_d   = 8'd0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_ok) begin
                        addr_d   = addr;
                        funct3_d = funct3;
                        cnt_d    = 8'd0;
                        state_d  = S_REQ;
                    end else begin
                        state_d = S_IDLE;
                        fault_d = start_bad;
                    end
                end
                S_REQ: begin
                    if (mem_ready) begin
                        data_d  = ext_data;
                        valid_d = 1'b1;
                        state_d = S_DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        fault_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            addr_q   <= 32'd0;
            funct3_q <= 3'd0;
            cnt_q    <= 8'd0;
            data_q   <= 32'd0;
            valid_q  <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            fault_q  <= fault_d;
        end
    end

    assign mem_req    = (state_q == S_REQ);
    assign mem_addr   = mem_req ? {addr_q[31:2], 2'b00} : 32'd0;
    // Low in DONE unless a new load is being accepted, so the pipeline
    // advances in the cycle that load_data is valid.
    assign load_stall = mem_req | (accepting & start_ok & ~flush);
    assign load_data  = data_q;
    assign load_valid = valid_q;
    assign load_fault = fault_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_load_unit.sv
module tb_load_unit;

    localparam logic [1:0] S_IDLE = 2'd0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_en = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic        flush = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        load_stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        load_fault;
    logic [1:0]  state_dbg;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_data = 32'd0;

    load_unit #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .load_en(load_en), .funct3(funct3),
        .addr(addr), .flush(flush), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .load_stall(load_stall),
        .load_data(load_data), .load_valid(load_valid),
        .load_fault(load_fault), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] rdata;
        logic [31:0] exp_data;
        logic        exp_fault;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled on
    // the falling edge so combinational outputs reflect this cycle's inputs.
    task automatic tick_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic accept_load(input logic [2:0] f3, input logic [31:0] a);
        tick_drive();
        load_en = 1'b1; funct3 = f3; addr = a; mem_ready = 1'b0; flush = 1'b0;
        sample();
        check("accept_stall", 32'(load_stall), 32'd1);
    endtask

    initial begin
        vecs[0]  = '{3'b010, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
        vecs[1]  = '{3'b000, 32'h203, 32'h80FF1234, 32'hFFFFFF80, 1'b0};
        vecs[2]  = '{3'b100, 32'h203, 32'h80FF1234, 32'h00000080, 1'b0};
        vecs[3]  = '{3'b101, 32'h202, 32'h80FF1234, 32'h000080FF, 1'b0};
        vecs[4]  = '{3'b001, 32'h200, 32'h80FF1234, 32'h00001234, 1'b0};
        vecs[5]  = '{3'b000, 32'h201, 32'h80FF1234, 32'h00000012, 1'b0};
        vecs[6]  = '{3'b001, 32'h202, 32'h80FF1234, 32'hFFFF80FF, 1'b0};
        vecs[7]  = '{3'b100, 32'h200, 32'h000000F0, 32'h000000F0, 1'b0};
        vecs[8]  = '{3'b010, 32'h102, 32'h11111111, 32'h0, 1'b1};
        vecs[9]  = '{3'b001, 32'h101, 32'h22222222, 32'h0, 1'b1};
        vecs[10] = '{3'b011, 32'h100, 32'h33333333, 32'h0, 1'b1};
        vecs[11] = '{3'b101, 32'h203, 32'h44444444, 32'h0, 1'b1};
        vecs[12] = '{3'b110, 32'h104, 32'h55555555, 32'h0, 1'b1};

        // ---- reset state ----
        #2;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_load_data", load_data, 32'd0);
        check("rst_valid", 32'(load_valid), 32'd0);
        check("rst_fault", 32'(load_fault), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(S_IDLE));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // ---- table-driven single loads, zero-wait memory ----
        for (int i = 0; i < 13; i++) begin
            logic [31:0] want;
            want = vecs[i].exp_fault ? last_data : vecs[i].exp_data;
            // cycle 0: present the load
            tick_drive();
            load_en = 1'b1; funct3 = vecs[i].f3; addr = vecs[i].a;
            sample();
            check($sformatf("v%0d_stall0", i), 32'(load_stall), 32'(!vecs[i].exp_fault));
            // cycle 1: REQ (legal) or fault pulse (illegal)
            tick_drive();
            load_en = 1'b0;
            mem_ready = !vecs[i].exp_fault;
            mem_rdata = vecs[i].rdata;
            sample();
            check($sformatf("v%0d_mem_req", i), 32'(mem_req), 32'(!vecs[i].exp_fault));
            if (!vecs[i].exp_fault)
                check($sformatf("v%0d_mem_addr", i), mem_addr, {vecs[i].a[31:2], 2'b00});
            check($sformatf("v%0d_fault1", i), 32'(load_fault), 32'(vecs[i].exp_fault));
            check($sformatf("v%0d_valid1", i), 32'(load_valid), 32'd0);
            check($sformatf("v%0d_stall1", i), 32'(load_stall), 32'(!vecs[i].exp_fault));
            // cycle 2: DONE (legal) or idle after fault
            tick_drive();
            mem_ready = 1'b0;
            sample();
            check($sformatf("v%0d_valid2", i), 32'(load_valid), 32'(!vecs[i].exp_fault));
            check($sformatf("v%0d_fault2", i), 32'(load_fault), 32'd0);
            check($sformatf("v%0d_data", i), load_data, want);
            check($sformatf("v%0d_stall2", i), 32'(load_stall), 32'd0);
            last_data = want;
        end

        // ---- timeout: mem_ready withheld ----
        begin
            int n;
            accept_load(3'b010, 32'h300);
            tick_drive();
            load_en = 1'b0; mem_ready = 1'b0;
            sample();
            n = 0;
            while (mem_req === 1'b1 && n < 40) begin
                n++;
                tick_drive();
                sample();
            end
            check("to_req_cycles", 32'(n), 32'd16);
            check("to_fault", 32'(load_fault), 32'd1);
            check("to_valid", 32'(load_valid), 32'd0);
            check("to_state", 32'(state_dbg), 32'(S_IDLE));
            check("to_data_kept", load_data, last_data);
            tick_drive();
            sample();
            check("to_fault_pulse", 32'(load_fault), 32'd0);
        end

        // ---- ready on the last permitted REQ cycle ----
        accept_load(3'b010, 32'h304);
        for (int i = 1; i <= 15; i++) begin
            tick_drive();
            load_en = 1'b0; mem_ready = 1'b0;
            sample();
            check($sformatf("late_req%0d", i), 32'(mem_req), 32'd1);
        end
        tick_drive();
        mem_ready = 1'b1; mem_rdata = 32'h12345678;
        sample();
        check("late_req16", 32'(mem_req), 32'd1);
        check("late_nofault16", 32'(load_fault), 32'd0);
        tick_drive();
        mem_ready = 1'b0;
        sample();
        check("late_valid", 32'(load_valid), 32'd1);
        check("late_nofault", 32'(load_fault), 32'd0);
        check("late_data", load_data, 32'h12345678);
        last_data = 32'h12345678;

        // ---- flush coinciding with mem_ready ----
        accept_load(3'b010, 32'h400);
        tick_drive();
        load_en = 1'b0; mem_ready = 1'b1; flush = 1'b1; mem_rdata = 32'hAAAA5555;
        sample();
        check("fl_req", 32'(mem_req), 32'd1);
        tick_drive();
        mem_ready = 1'b0; flush = 1'b0;
        sample();
        check("fl_valid", 32'(load_valid), 32'd0);
        check("fl_fault", 32'(load_fault), 32'd0);
        check("fl_data", load_data, last_data);
        check("fl_state", 32'(state_dbg), 32'(S_IDLE));
        check("fl_mem_req", 32'(mem_req), 32'd0);

        // ---- back-to-back word loads, zero-wait memory ----
        begin
            int valids = 0;
            logic [31:0] rd;
            tick_drive();
            load_en = 1'b1; funct3 = 3'b010; addr = 32'h500;
            for (int k = 0; k < 4; k++) begin
                // REQ cycle
                tick_drive();
                load_en = 1'b0;
                rd = 32'hC0DE0000 + 32'(k * 32'h1111);
                mem_ready = 1'b1; mem_rdata = rd;
                exp_q.push_back(rd);
                sample();
                check($sformatf("b2b_addr%0d", k), mem_addr, 32'h500 + 32'(4 * k));
                // DONE cycle, next load presented (except after the last)
                tick_drive();
                mem_ready = 1'b0;
                load_en = (k < 3);
                addr = 32'h500 + 32'(4 * (k + 1));
                sample();
                if (load_valid === 1'b1) begin
                    valids++;
                    if (exp_q.size() > 0)
                        check($sformatf("b2b_data%0d", k), load_data, exp_q.pop_front());
                end
                check($sformatf("b2b_stall%0d", k), 32'(load_stall), 32'(k < 3));
            end
            check("b2b_valids", 32'(valids), 32'd4);
            check("b2b_queue_empty", 32'(exp_q.size()), 32'd0);
            last_data = rd;
            load_en = 1'b0;
        end

        // ---- reset asserted in the middle of REQ ----
        tick_drive();
        sample();
        accept_load(3'b010, 32'h600);
        tick_drive();
        load_en = 1'b0; mem_ready = 1'b0;
        sample();
        check("rr_req_before", 32'(mem_req), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("rr_mem_req", 32'(mem_req), 32'd0);
        check("rr_mem_addr", mem_addr, 32'd0);
        check("rr_data", load_data, 32'd0);
        check("rr_valid", 32'(load_valid), 32'd0);
        check("rr_fault", 32'(load_fault), 32'd0);
        check("rr_stall", 32'(load_stall), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick_drive();
        mem_ready = 1'b1; mem_rdata = 32'hFFFFFFFF;
        sample();
        check("rr_after_req", 32'(mem_req), 32'd0);
        tick_drive();
        mem_ready = 1'b0;
        sample();
        check("rr_after_valid", 32'(load_valid), 32'd0);
        check("rr_after_data", load_data, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $finish;
    end

endmodule
